fsm_with_scan: RTL and testbench



---
 rtl/fsm_scan_pkg.sv | 13 +
 rtl/scan_dff.sv | 28 ++
 rtl/fsm_with_scan.sv | 59 +++++
 tb/tb_fsm_with_scan.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fsm_scan_pkg.sv
// fsm_scan_pkg
// Shared definitions for the scan-inserted sequencing FSM: the 2-bit state
// type and the fixed state encodings. 2'b10 is deliberately left unnamed;
// it is an illegal encoding that can only be reached by shifting it in.
package fsm_scan_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'b00;
    localparam state_t ST_LOAD    = 2'b01;
    localparam state_t ST_PROCESS = 2'b11;

endpackage : fsm_scan_pkg

// File: rtl/scan_dff.sv
// scan_dff
// Mux-D scan flop. In functional mode it captures d; in scan mode it
// captures si so that a string of these forms a serial shift chain.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset, clears q to 0
//   scan_en - 1 selects si, 0 selects d
//   d       - functional data input
//   si      - scan data input
//   q       - flop output
module scan_dff (
    input  logic clk,
    input  logic rst,
    input  logic scan_en,
    input  logic d,
    input  logic si,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= scan_en ? si : d;
        end
    end

endmodule : scan_dff

// File: rtl/fsm_with_scan.sv
// fsm_with_scan
// Free-running three-state sequencer IDLE -> LOAD -> PROCESS -> IDLE whose
// two state flops double as a scan chain: scan_in -> state[0] -> state[1]
// -> scan_out.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, forces IDLE immediately
//   scan_en  - 1 = shift mode, 0 = functional mode
//   scan_in  - serial scan data input
//   scan_out - serial scan data output, a direct tap of state[1]
//   state    - current state register contents
module fsm_with_scan
    import fsm_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       scan_in,
    output logic       scan_out,
    output logic [1:0] state
);

    state_t next_state;

    // Functional next state. The unused encoding falls into the default arm
    // so a shifted-in 10 recovers to IDLE on the first functional edge.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:    next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_PROCESS;
            ST_PROCESS: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Bit 0 is the head of the chain; bit 1 shifts from bit 0.
    scan_dff u_state0 (
        .clk     (clk),
        .rst     (rst),
        .scan_en (scan_en),
        .d       (next_state[0]),
        .si      (scan_in),
        .q       (state[0])
    );

    scan_dff u_state1 (
        .clk     (clk),
        .rst     (rst),
        .scan_en (scan_en),
        .d       (next_state[1]),
        .si      (state[0]),
        .q       (state[1])
    );

    // Unregistered tap of the last flop keeps shift latency at two edges.
    assign scan_out = state[1];

endmodule : fsm_with_scan

// File: tb/tb_fsm_with_scan.sv
// tb_fsm_with_scan
// Directed, table-driven bench for fsm_with_scan plus hand-written
// sequences for asynchronous reset and scan-input isolation.
module tb_fsm_with_scan;

    logic       clk;
    logic       rst;
    logic       scan_en;
    logic       scan_in;
    logic       scan_out;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         rst_before;
        bit         se;
        bit         si;
        logic [1:0] exp_state;
        logic       exp_so;
        string      name;
    } vec_t;

    vec_t vecs[$];

    fsm_with_scan dut (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check2(input string nm, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, got, exp);
        end
    endtask

    task automatic check1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit se, input bit si,
                                input logic [1:0] st, input string nm);
        vec_t v;
        v.rst_before = r;
        v.se         = se;
        v.si         = si;
        v.exp_state  = st;
        v.exp_so     = st[1];
        v.name       = nm;
        return v;
    endfunction

    initial begin
        rst     = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;

        // Functional sequence after reset
        vecs.push_back(mk(1, 0, 0, 2'b01, "func_e1"));
        vecs.push_back(mk(0, 0, 0, 2'b11, "func_e2"));
        vecs.push_back(mk(0, 0, 0, 2'b00, "func_e3"));
        vecs.push_back(mk(0, 0, 0, 2'b01, "func_e4"));
        // Shift 1,0,1,1
        vecs.push_back(mk(1, 1, 1, 2'b01, "shift_e1"));
        vecs.push_back(mk(0, 1, 0, 2'b10, "shift_e2"));
        vecs.push_back(mk(0, 1, 1, 2'b01, "shift_e3"));
        vecs.push_back(mk(0, 1, 1, 2'b11, "shift_e4"));
        // Shift in illegal 10, then recover functionally
        vecs.push_back(mk(1, 1, 1, 2'b01, "ill_shift1"));
        vecs.push_back(mk(0, 1, 0, 2'b10, "ill_shift2"));
        vecs.push_back(mk(0, 0, 0, 2'b00, "ill_recover"));
        vecs.push_back(mk(0, 0, 0, 2'b01, "ill_next"));
        // Unload PROCESS through the chain
        vecs.push_back(mk(1, 0, 0, 2'b01, "unl_f1"));
        vecs.push_back(mk(0, 0, 0, 2'b11, "unl_f2"));
        vecs.push_back(mk(0, 1, 0, 2'b10, "unl_s1"));
        vecs.push_back(mk(0, 1, 0, 2'b00, "unl_s2"));
        // Scan exit from 01 advances to 11
        vecs.push_back(mk(1, 1, 1, 2'b01, "exit_shift"));
        vecs.push_back(mk(0, 0, 0, 2'b11, "exit_func"));

        #2 rst = 1'b1;
        #1;
        check2("init_rst_state", state, 2'b00);
        check1("init_rst_so", scan_out, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].rst_before) begin
                rst = 1'b1;
                #1;
                check2({vecs[i].name, "_rst_state"}, state, 2'b00);
                check1({vecs[i].name, "_rst_so"}, scan_out, 1'b0);
                #1 rst = 1'b0;
            end
            scan_en = vecs[i].se;
            scan_in = vecs[i].si;
            @(posedge clk);
            #1;
            check2({vecs[i].name, "_state"}, state, vecs[i].exp_state);
            check1({vecs[i].name, "_so"}, scan_out, vecs[i].exp_so);
        end

        // Asynchronous reset between edges while holding 11 in scan mode
        @(negedge clk);
        scan_en = 1'b1;
        scan_in = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        scan_in = 1'b1;
        @(posedge clk);
        #1;
        check2("arst_pre_state", state, 2'b11);
        #2 rst = 1'b1;
        #1;
        check2("arst_now_state", state, 2'b00);
        check1("arst_now_so", scan_out, 1'b0);
        @(posedge clk);
        #1;
        check2("arst_held_state", state, 2'b00);
        @(negedge clk);
        rst     = 1'b0;
        scan_in = 1'b1;
        @(posedge clk);
        #1;
        check2("arst_resume_state", state, 2'b01);

        // scan_in changes between edges must not reach the outputs
        @(negedge clk);
        scan_in = 1'b0;
        #1;
        check2("iso_state_a", state, 2'b01);
        scan_in = 1'b1;
        #1;
        check2("iso_state_b", state, 2'b01);
        check1("iso_so", scan_out, 1'b0);
        @(posedge clk);
        #1;
        check2("iso_shift_state", state, 2'b11);
        check1("iso_shift_so", scan_out, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fsm_with_scan
